// File: rtl/sr_flag_ctrl.sv
// Bank of set/reset status flags driven by two round-robin arbitrated requesters.
// Supports set, clear and fixed-length pulse commands, one command applied per cycle.
module sr_flag_ctrl #(
   parameter int unsigned NUM_FLAGS = 8,
   parameter int unsigned PULSE_LEN = 4,
   parameter int unsigned IDX_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 a_valid,
   input  logic [1:0]           a_op,
   input  logic [IDX_W-1:0]     a_idx,
   output logic                 a_ready,
   input  logic                 b_valid,
   input  logic [1:0]           b_op,
   input  logic [IDX_W-1:0]     b_idx,
   output logic                 b_ready,
   output logic [NUM_FLAGS-1:0] q,
   output logic                 busy,
   output logic                 err_conflict,
   output logic                 err_range
);

   localparam int unsigned CNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(PULSE_LEN - 1);

   localparam logic [0:0] StIdle  = 1'b0;
   localparam logic [0:0] StPulse = 1'b1;

   localparam logic [1:0] OpNop   = 2'b00;
   localparam logic [1:0] OpClear = 2'b01;
   localparam logic [1:0] OpSet   = 2'b10;
   localparam logic [1:0] OpPulse = 2'b11;

   logic [0:0]           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [NUM_FLAGS-1:0] flags_q, flags_d;
   logic [NUM_FLAGS-1:0] pmask_q, pmask_d;
   logic                 rr_q, rr_d;  // 0 favours A, 1 favours B
   logic                 ec_q, ec_d;
   logic                 er_q, er_d;

   logic                 idle, grant_a, grant_b, accept, in_range;
   logic [1:0]           sel_op;
   logic [IDX_W-1:0]     sel_idx;
   logic [NUM_FLAGS-1:0] sel_mask;

   always_comb begin
      idle    = (state_q == StIdle);
      grant_a = idle && a_valid && (!b_valid || !rr_q);
      grant_b = idle && b_valid && (!a_valid ||  rr_q);
      accept  = grant_a || grant_b;
      sel_op  = grant_b ? b_op  : a_op;
      sel_idx = grant_b ? b_idx : a_idx;

      // An out-of-range index matches no bit, so an empty mask flags a range error.
      sel_mask = '0;
      for (int i = 0; i < NUM_FLAGS; i++) begin
         if (sel_idx == IDX_W'(i)) sel_mask[i] = 1'b1;
      end
      in_range = |sel_mask;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      flags_d = flags_q;
      pmask_d = pmask_q;
      rr_d    = rr_q;
      ec_d    = 1'b0;
      er_d    = 1'b0;

      if (idle) begin
         if (a_valid && b_valid) begin
            rr_d = ~rr_q;
            ec_d = (a_idx == b_idx) && (a_op != b_op);
         end
         if (accept) begin
            er_d = !in_range;
            unique case (sel_op)
               OpClear: flags_d = flags_q & ~sel_mask;
               OpSet:   flags_d = flags_q | sel_mask;
               OpPulse: begin
                  if (in_range) begin
                     flags_d = flags_q | sel_mask;
                     pmask_d = sel_mask;
                     cnt_d   = CNT_INIT;
                     state_d = StPulse;
                  end
               end
               default: ;
            endcase
         end
      end else begin
         if (cnt_q == '0) begin
            flags_d = flags_q & ~pmask_q;
            state_d = StIdle;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         flags_q <= '0;
         pmask_q <= '0;
         rr_q    <= 1'b0;
         ec_q    <= 1'b0;
         er_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         flags_q <= flags_d;
         pmask_q <= pmask_d;
         rr_q    <= rr_d;
         ec_q    <= ec_d;
         er_q    <= er_d;
      end
   end

   assign a_ready      = grant_a;
   assign b_ready      = grant_b;
   assign q            = flags_q;
   assign busy         = (state_q == StPulse);
   assign err_conflict = ec_q;
   assign err_range    = er_q;

endmodule
